key_debounce_multi: RTL and testbench
=====================================

// Module: key_debounce_multi
// PURPOSE
//  Parametrised N-channel key debouncer for the taximeter front panel.
//  Per key: 2-FF synchroniser, stable-time filter, debounced level, and
//  one-cycle press/release pulses. Adds long-press detect and optional
//  auto-repeat. Sits between raw key pins and the fare/mode control FSMs.
// PARAMETERS
//  N_KEYS      4       number of independent key channels
//  STABLE_CYC  262144  cycles a new synced level must persist to be accepted (>=1)
//  LONG_CYC    6000000 cycles held (after press pulse) before long pulse (>=1)
//  REPEAT_CYC  1200000 repeat period after long press; 0 = repeat disabled
//  ACTIVE_LOW  1       1: pressed = 0 (idle high), 0: pressed = 1
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  key_in       in   N_KEYS  raw key pins, asynchronous
//  key_level    out  N_KEYS  debounced state, 1 = pressed (polarity normalised)
//  key_press    out  N_KEYS  1-cycle pulse on accepted press
//  key_release  out  N_KEYS  1-cycle pulse on accepted release
//  key_long     out  N_KEYS  1-cycle pulse when held LONG_CYC cycles
//  key_repeat   out  N_KEYS  1-cycle pulse every REPEAT_CYC cycles after long
// BEHAVIOUR
//  Reset (rst_n=0, async): sync FFs = idle level (1 if ACTIVE_LOW else 0);
//   stable state = released; all counters 0; all outputs 0.
//  Channels fully independent; same logic replicated N_KEYS times.
//  Sync: s1<=key_in[i]; s2<=s1. Norm p = ACTIVE_LOW ? ~s2 : s2.
//  Stable filter, counter cnt width $clog2(STABLE_CYC+1):
//   - p == key_level: cnt<=0 (any glitch restarts the count).
//   - p != key_level and cnt < STABLE_CYC-1: cnt<=cnt+1.
//   - p != key_level and cnt == STABLE_CYC-1: key_level<=p, cnt<=0,
//     key_press (p=1) or key_release (p=0) high for exactly that next cycle.
//  Latency: key_in changed and held from sampling edge k -> key_level and
//   pulse update at edge k+STABLE_CYC+1. Pulses shorter than STABLE_CYC
//   cycles (post-sync) never change key_level and produce no pulse.
//  Hold counter hcnt width $clog2(max(LONG_CYC,REPEAT_CYC)+1), state LONG:
//   - states IDLE, HOLD, LONG. IDLE->HOLD on accepted press, hcnt<=0.
//   - HOLD: hcnt increments each cycle; at hcnt==LONG_CYC-1: key_long
//     pulse, hcnt<=0, ->LONG. key_long occurs LONG_CYC cycles after key_press.
//   - LONG, REPEAT_CYC>0: hcnt increments; at REPEAT_CYC-1 key_repeat
//     pulse, hcnt<=0, stay LONG. REPEAT_CYC=0: hcnt frozen, no pulses.
//   - Accepted release in HOLD or LONG -> IDLE, hcnt<=0, no long/repeat
//     pulse that cycle even if counter terminal coincides (release wins).
//  key_press and key_long never asserted in the same cycle (LONG_CYC>=1).
//  Counters never wrap: all are cleared at terminal count.
//  Reset mid-operation: immediate return to reset state; pending
//   counts discarded; no pulse emitted on reset release.
//  Releasing rst_n with key held: press accepted STABLE_CYC+2 cycles later.
// TESTING  (bench params: N_KEYS=2, STABLE_CYC=4, LONG_CYC=10, REPEAT_CYC=3, ACTIVE_LOW=1)
//  1 key_in[0] 1->0 held at edge k -> key_press[0]=1 only after edge k+5,
//    key_level[0]=1 thereafter; key_*[1] stay 0.
//  2 key_in[0] low for 3 cycles then high (bounce) -> no pulses, level 0;
//    bounce train then stable low -> exactly one key_press, 5 cycles after last edge.
//  3 Hold key 0 for 20 cycles after press -> key_long 10 cycles after press,
//    key_repeat at +13, +16, +19; release -> single key_release, no more pulses.
//  4 REPEAT_CYC=0 rerun of 3 -> key_long once, key_repeat never asserts.
//  5 Release accepted same cycle hcnt hits LONG_CYC-1 -> key_release=1, key_long=0.
//  6 Async rst_n low mid-HOLD for 2 cycles with key still held -> all outputs 0
//    at once; key_press reasserts 6 cycles after rst_n rises; both keys together -> simultaneous independent pulses.

Source files
------------

// File: rtl/key_debounce_multi.sv
// rtl/key_debounce_multi.sv - N-channel key debouncer with press/release pulses, long-press and auto-repeat
module key_debounce_multi #(
  parameter int N_KEYS     = 4,
  parameter int STABLE_CYC = 262144,
  parameter int LONG_CYC   = 6000000,
  parameter int REPEAT_CYC = 1200000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int CW   = $clog2(STABLE_CYC + 1);
  localparam int HMAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYC - 1);
  localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] REPEAT_LAST = HW'((REPEAT_CYC > 0) ? (REPEAT_CYC - 1) : 0);
  localparam logic          IDLE_LVL    = (ACTIVE_LOW != 0);
  localparam logic          REPEAT_EN   = (REPEAT_CYC > 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_LONG = 2'd2
  } hold_state_e;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic          s1_q, s1_d, s2_q, s2_d;
    logic          p;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    hold_state_e   state_q, state_d;
    logic          acc_press, acc_release;

    // XOR with the idle level folds both polarities into "1 = pressed".
    assign p = s2_q ^ IDLE_LVL;

    always_comb begin
      s1_d        = key_in[i];
      s2_d        = s1_q;
      level_d     = level_q;
      cnt_d       = '0;
      acc_press   = 1'b0;
      acc_release = 1'b0;
      state_d     = state_q;
      hcnt_d      = hcnt_q;
      long_d      = 1'b0;
      repeat_d    = 1'b0;

      if (p != level_q) begin
        if (cnt_q == STABLE_LAST) begin
          level_d     = p;
          acc_press   = p;
          acc_release = ~p;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      press_d   = acc_press;
      release_d = acc_release;

      // A release accepted on the terminal cycle suppresses long/repeat.
      case (state_q)
        ST_IDLE: begin
          if (acc_press) begin
            state_d = ST_HOLD;
            hcnt_d  = '0;
          end
        end
        ST_HOLD: begin
          if (acc_release) begin
            state_d = ST_IDLE;
            hcnt_d  = '0;
          end else if (hcnt_q == LONG_LAST) begin
            long_d  = 1'b1;
            hcnt_d  = '0;
            state_d = ST_LONG;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        ST_LONG: begin
          if (acc_release) begin
            state_d = ST_IDLE;
            hcnt_d  = '0;
          end else if (REPEAT_EN) begin
            if (hcnt_q == REPEAT_LAST) begin
              repeat_d = 1'b1;
              hcnt_d   = '0;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          hcnt_d  = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q      <= IDLE_LVL;
        s2_q      <= IDLE_LVL;
        level_q   <= 1'b0;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        hcnt_q    <= '0;
        state_q   <= ST_IDLE;
      end else begin
        s1_q      <= s1_d;
        s2_q      <= s2_d;
        level_q   <= level_d;
        cnt_q     <= cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
        repeat_q  <= repeat_d;
        hcnt_q    <= hcnt_d;
        state_q   <= state_d;
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;
    assign key_repeat[i]  = repeat_q;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb/tb_key_debounce_multi.sv - bench for key_debounce_multi: directed scenarios plus random run against a window/time model
module tb_key_debounce_multi;

  localparam int S = 4;
  localparam int L = 10;
  localparam int R = 3;

  logic       clk;
  logic       rst_n;
  logic [1:0] key_in;
  logic [1:0] key_level, key_press, key_release, key_long, key_repeat;
  logic [1:0] nr_level, nr_press, nr_release, nr_long, nr_repeat;

  int total;
  int bad;
  int edge_n;

  bit         m_hist [2][S+2];
  bit         m_level [2];
  bit         m_held [2];
  int         m_press_edge [2];
  logic [1:0] e_level, e_press, e_release, e_long, e_rep;

  key_debounce_multi #(
    .N_KEYS(2), .STABLE_CYC(S), .LONG_CYC(L), .REPEAT_CYC(R), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_repeat(key_repeat)
  );

  key_debounce_multi #(
    .N_KEYS(2), .STABLE_CYC(S), .LONG_CYC(L), .REPEAT_CYC(0), .ACTIVE_LOW(1)
  ) dut_nr (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_level(nr_level), .key_press(nr_press), .key_release(nr_release),
    .key_long(nr_long), .key_repeat(nr_repeat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < S + 2; j++) m_hist[i][j] = 1'b0;
      m_level[i]      = 1'b0;
      m_held[i]       = 1'b0;
      m_press_edge[i] = 0;
    end
    e_level = '0; e_press = '0; e_release = '0; e_long = '0; e_rep = '0;
  endtask

  // Level flips once the S samples that have passed the synchroniser all disagree with it;
  // long/repeat are timed arithmetically from the press edge while the key stays accepted.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit flip;
      int d;
      for (int j = S + 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
      m_hist[i][0] = ~key_in[i];
      flip = 1'b1;
      for (int j = 2; j <= S + 1; j++) if (m_hist[i][j] == m_level[i]) flip = 1'b0;
      e_press[i] = 1'b0; e_release[i] = 1'b0; e_long[i] = 1'b0; e_rep[i] = 1'b0;
      if (flip) begin
        m_level[i] = ~m_level[i];
        if (m_level[i]) begin
          e_press[i]      = 1'b1;
          m_held[i]       = 1'b1;
          m_press_edge[i] = edge_n;
        end else begin
          e_release[i] = 1'b1;
          m_held[i]    = 1'b0;
        end
      end else if (m_held[i]) begin
        d          = edge_n - m_press_edge[i];
        e_long[i]  = (d == L);
        e_rep[i]   = (d > L) && ((d - L) % R == 0);
      end
      e_level[i] = m_level[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic settle();
    key_in = 2'b11;
    repeat (14) tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    if ({key_level, key_press, key_release, key_long, key_repeat} !== 10'b0) begin
      bad++; $display("FAIL reset_outputs got=%b want=0", {key_level, key_press, key_release, key_long, key_repeat});
    end
    total++;
    #2 rst_n = 1'b1;
    repeat (5) tick();
    if ({key_level, key_press, nr_level, nr_press} !== 8'b0) begin
      bad++; $display("FAIL idle_after_reset got=%b want=0", {key_level, key_press, nr_level, nr_press});
    end
    total++;
  endtask

  task automatic test_press();
    key_in = 2'b10;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (key_press !== ((t == 6) ? 2'b01 : 2'b00)) begin
        bad++; $display("FAIL press_timing t=%0d got=%b want=%b", t, key_press, (t == 6) ? 2'b01 : 2'b00);
      end
      total++;
      if (key_level !== ((t == 6) ? 2'b01 : 2'b00)) begin
        bad++; $display("FAIL press_level t=%0d got=%b want=%b", t, key_level, (t == 6) ? 2'b01 : 2'b00);
      end
      total++;
    end
    key_in = 2'b11;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (key_release !== ((t == 6) ? 2'b01 : 2'b00)) begin
        bad++; $display("FAIL release_timing t=%0d got=%b want=%b", t, key_release, (t == 6) ? 2'b01 : 2'b00);
      end
      total++;
      if ({key_level, key_long, key_press} !== ((t == 6) ? 6'b0 : 6'b010000)) begin
        bad++; $display("FAIL release_level t=%0d got=%b", t, {key_level, key_long, key_press});
      end
      total++;
    end
  endtask

  task automatic test_bounce();
    int runs [8] = '{2, 1, 3, 2, 1, 1, 3, 2};
    int npress;
    int at;
    key_in = 2'b10;
    for (int t = 1; t <= 13; t++) begin
      if (t == 4) key_in = 2'b11;
      tick();
      if ({key_press, key_level, key_release} !== 6'b0) begin
        bad++; $display("FAIL short_pulse t=%0d got=%b want=0", t, {key_press, key_level, key_release});
      end
      total++;
    end
    npress = 0;
    at     = -1;
    for (int k = 0; k < 8; k++) begin
      key_in[0] = (k % 2 == 0) ? 1'b0 : 1'b1;
      repeat (runs[k]) begin
        tick();
        if (key_press[0]) npress++;
      end
    end
    key_in[0] = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (key_press[0]) begin
        npress++;
        at = t;
      end
    end
    if (npress !== 1) begin
      bad++; $display("FAIL bounce_count got=%0d want=1", npress);
    end
    total++;
    if (at !== 6) begin
      bad++; $display("FAIL bounce_latency got=%0d want=6", at);
    end
    total++;
    settle();
  endtask

  task automatic test_long();
    key_in = 2'b10;
    repeat (6) tick();
    if (key_press !== 2'b01) begin
      bad++; $display("FAIL long_press got=%b want=01", key_press);
    end
    total++;
    for (int t = 1; t <= 35; t++) begin
      logic el, er, erel;
      if (t == 21) key_in = 2'b11;
      tick();
      el   = (t == L);
      er   = (t > L) && (t < 26) && ((t - L) % R == 0);
      erel = (t == 26);
      if (key_long !== {1'b0, el}) begin
        bad++; $display("FAIL long_pulse t=%0d got=%b want=%b", t, key_long, {1'b0, el});
      end
      total++;
      if (key_repeat !== {1'b0, er}) begin
        bad++; $display("FAIL repeat_pulse t=%0d got=%b want=%b", t, key_repeat, {1'b0, er});
      end
      total++;
      if (key_release !== {1'b0, erel}) begin
        bad++; $display("FAIL long_release t=%0d got=%b want=%b", t, key_release, {1'b0, erel});
      end
      total++;
    end
    settle();
  endtask

  task automatic test_no_repeat();
    key_in = 2'b10;
    repeat (6) tick();
    for (int t = 1; t <= 35; t++) begin
      if (t == 21) key_in = 2'b11;
      tick();
      if (nr_long !== ((t == L) ? 2'b01 : 2'b00)) begin
        bad++; $display("FAIL norep_long t=%0d got=%b want=%b", t, nr_long, (t == L) ? 2'b01 : 2'b00);
      end
      total++;
      if (nr_repeat !== 2'b00) begin
        bad++; $display("FAIL norep_repeat t=%0d got=%b want=00", t, nr_repeat);
      end
      total++;
    end
    settle();
  endtask

  task automatic test_release_wins();
    key_in = 2'b10;
    repeat (6) tick();
    for (int t = 1; t <= 14; t++) begin
      if (t == 5) key_in = 2'b11;
      tick();
      if (key_release !== ((t == L) ? 2'b01 : 2'b00)) begin
        bad++; $display("FAIL rw_release t=%0d got=%b want=%b", t, key_release, (t == L) ? 2'b01 : 2'b00);
      end
      total++;
      if ({key_long, key_repeat, nr_long} !== 6'b0) begin
        bad++; $display("FAIL rw_long t=%0d got=%b want=0", t, {key_long, key_repeat, nr_long});
      end
      total++;
    end
    settle();
  endtask

  task automatic test_reset_mid();
    key_in = 2'b00;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (key_press !== ((t == 6) ? 2'b11 : 2'b00)) begin
        bad++; $display("FAIL dual_press t=%0d got=%b want=%b", t, key_press, (t == 6) ? 2'b11 : 2'b00);
      end
      total++;
    end
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1 model_reset();
    if ({key_level, key_press, key_release, key_long, key_repeat} !== 10'b0) begin
      bad++; $display("FAIL async_reset got=%b want=0", {key_level, key_press, key_release, key_long, key_repeat});
    end
    total++;
    for (int t = 1; t <= 2; t++) begin
      tick();
      if ({key_level, key_press, key_release, key_long, key_repeat} !== 10'b0) begin
        bad++; $display("FAIL reset_hold t=%0d got=%b want=0", t, {key_level, key_press, key_release, key_long, key_repeat});
      end
      total++;
    end
    #2 rst_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (key_press !== ((t == 6) ? 2'b11 : 2'b00)) begin
        bad++; $display("FAIL repress t=%0d got=%b want=%b", t, key_press, (t == 6) ? 2'b11 : 2'b00);
      end
      total++;
      if (key_level !== ((t >= 6) ? 2'b11 : 2'b00)) begin
        bad++; $display("FAIL repress_level t=%0d got=%b want=%b", t, key_level, (t >= 6) ? 2'b11 : 2'b00);
      end
      total++;
    end
    settle();
  endtask

  task automatic test_random();
    int rem [2];
    rem[0] = 0;
    rem[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (rem[i] == 0) begin
          key_in[i] = ~key_in[i];
          if ($urandom_range(0, 5) == 0) rem[i] = $urandom_range(15, 40);
          else rem[i] = $urandom_range(1, 6);
        end else begin
          rem[i]--;
        end
      end
      tick();
      if (key_level !== e_level) begin
        bad++; $display("FAIL rnd_level c=%0d got=%b want=%b", c, key_level, e_level);
      end
      total++;
      if (key_press !== e_press) begin
        bad++; $display("FAIL rnd_press c=%0d got=%b want=%b", c, key_press, e_press);
      end
      total++;
      if (key_release !== e_release) begin
        bad++; $display("FAIL rnd_release c=%0d got=%b want=%b", c, key_release, e_release);
      end
      total++;
      if (key_long !== e_long) begin
        bad++; $display("FAIL rnd_long c=%0d got=%b want=%b", c, key_long, e_long);
      end
      total++;
      if (key_repeat !== e_rep) begin
        bad++; $display("FAIL rnd_repeat c=%0d got=%b want=%b", c, key_repeat, e_rep);
      end
      total++;
      if (nr_long !== e_long) begin
        bad++; $display("FAIL rnd_nr_long c=%0d got=%b want=%b", c, nr_long, e_long);
      end
      total++;
      if (nr_repeat !== 2'b00) begin
        bad++; $display("FAIL rnd_nr_repeat c=%0d got=%b want=00", c, nr_repeat);
      end
      total++;
    end
    settle();
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    edge_n = 0;
    rst_n  = 1'b0;
    key_in = 2'b11;
    model_reset();
    test_reset();
    test_press();
    test_bounce();
    test_long();
    test_no_repeat();
    test_release_wins();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
